com_timer_tick_master: RTL and testbench
========================================

# com_timer_tick_master

Avalon-MM initiator that owns the 16-bit register port of the system's periodic communication interval timer and services it in hardware. After reset it enables the timer interrupt, then on every timer `irq` it reads the status register, acknowledges the timeout, and advances a free-running tick count. The tick count and pulse drive the Car2X communication scheduler, so the Nios CPU no longer takes the interrupt. It also issues a period-register write on request, which forces the timer to reload and resynchronise its phase.

## Interface
Parameters:
- `TICK_W`, 32: width of `tick_count`.
- `CTRL_INIT`, 16'h0001: value written to timer control register (address 1) during init; bit0 = interrupt enable.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  service enable; low = irq ignored (no new service sequence started).
- `resync`  in  1  single-cycle request to force timer reload.
- `irq`  in  1  timer interrupt (level, from timer registers).
- `address`  out  3  timer register address.
- `chipselect`  out  1  bus cycle active.
- `write_n`  out  1  active-low write strobe.
- `writedata`  out  16  write data.
- `readdata`  in  16  timer read data; registered in the timer, valid exactly one cycle after address is presented; no waitrequest.
- `ready`  out  1  init write complete.
- `tick_pulse`  out  1  one-cycle pulse per acknowledged timeout.
- `tick_count`  out  TICK_W  acknowledged timeouts since reset.
- `spurious_count`  out  8  service sequences whose status bit0 read 0.

## Operation
- Timer register map: 0 status (bit0 timeout, bit1 running; any write clears timeout), 1 control (bit0 irq enable), 2/3 period low/high (any write forces reload).
- States:
  - INIT: write `CTRL_INIT` to address 1 for one cycle → IDLE; `ready` set on entry to IDLE and held until reset.
  - IDLE: bus idle.
    - `irq && en` → RD_ADDR.
    - Else pending resync → RESYNC.
    - irq has priority over resync.
  - RD_ADDR: chipselect=1, write_n=1, address=0 → RD_CAP.
  - RD_CAP: chipselect=0, address held 0; sample `readdata` at end of cycle.
    - bit0=1 → ACK.
    - bit0=0 → `spurious_count`+1, saturating at 255 → IDLE.
  - ACK: write 16'h0000 to address 0 → IDLE; `tick_count`+1 (wraps modulo 2^TICK_W) and `tick_pulse`=1, both registered at end of ACK.
  - RESYNC: write 16'h0000 to address 2 → IDLE; clears pending flag.
- `resync` sets a sticky pending flag in any state, including INIT. Multiple requests before service merge into one write.
- `en` low mid-sequence: the current sequence completes; only new starts are blocked.
- Bus idle values, driven in every state not listed as a bus cycle: chipselect=0, write_n=1, writedata=0, address=0. Every bus cycle is exactly one clock.

## Timing
- Reset values: address=0, chipselect=0, write_n=1, writedata=0, ready=0, tick_pulse=0, tick_count=0, spurious_count=0, pending=0, state=INIT.
- After reset deassertion: INIT write on first clock, `ready`=1 from second clock.
- irq to ack: irq seen in IDLE at cycle N; read at N+1; capture at N+2; ack write at N+3; `tick_pulse` high and `tick_count` updated in cycle N+4.
- The timer drops irq at the edge ending ACK, so IDLE at N+4 sees irq low. Back-to-back service without a gap is not possible; minimum service period is 4 cycles.
- resync latency from IDLE with irq low: write in the next cycle.
- Reset asserted mid-sequence: all outputs return to reset values asynchronously; INIT reruns after release.

## Test plan
- Reset release with timer model → one write of 16'h0001 to address 1 on the first clock; `ready`=1 on the second; no other bus cycles.
- irq with status 16'h0003 → read address 0, then write 16'h0000 to address 0 three cycles after irq; `tick_pulse` one cycle; `tick_count` 0→1; irq low afterwards.
- irq forced high while status reads 16'h0002 → no write; `spurious_count`=1. Holding irq for 300 sequences → `spurious_count` saturates at 255.
- `resync` pulsed twice during a service sequence → after ACK, exactly one write of 16'h0000 to address 2; irq and resync asserted together in IDLE → service first, then resync.
- `TICK_W`=4 with 17 timeouts → `tick_count` wraps 15→0 and ends at 1; `en`=0 with irq high → bus stays idle until `en`=1.
- Reset asserted during RD_CAP → outputs at reset values immediately; INIT write repeats after release.

Source files
------------

// File: rtl/com_timer_tick_master.sv
// Avalon-MM initiator that services the periodic interval timer in hardware:
// enables its interrupt, acknowledges each timeout, counts ticks, and forces reloads.
module com_timer_tick_master #(
    parameter int unsigned TICK_W    = 32,
    parameter logic [15:0] CTRL_INIT = 16'h0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              resync,
    input  logic              irq,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [15:0]       writedata,
    input  logic [15:0]       readdata,
    output logic              ready,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic [7:0]        spurious_count
);

    localparam logic [2:0] ADDR_STATUS    = 3'd0;
    localparam logic [2:0] ADDR_CTRL      = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_LO = 3'd2;
    localparam logic [7:0] SPUR_MAX       = 8'hFF;

    // S_INIT is the reset state; the control write itself occupies S_INIT_WR
    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_INIT_WR = 3'd1,
        S_IDLE    = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_CAP  = 3'd4,
        S_ACK     = 3'd5,
        S_RESYNC  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [2:0]          r_address;
    logic                r_chipselect;
    logic                r_write_n;
    logic [15:0]         r_writedata;
    logic                r_ready;
    logic                r_tick_pulse;
    logic [TICK_W-1:0]   r_tick_count;
    logic [7:0]          r_spurious_count;
    logic                r_pending;

    logic [2:0]          w_address;
    logic                w_chipselect;
    logic                w_write_n;
    logic [15:0]         w_writedata;
    logic                w_ready;
    logic                w_tick_pulse;
    logic [TICK_W-1:0]   w_tick_count;
    logic [7:0]          w_spurious_count;
    logic                w_pending;
    logic                w_pending_next;
    logic                w_readdata_unused;

    // Only the timeout flag of the status word matters here
    assign w_readdata_unused = ^readdata[15:1];

    // A request arriving this cycle is already visible to the IDLE decision
    assign w_pending = r_pending | resync;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; irq service takes priority over a pending reload
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:    w_next_state = S_INIT_WR;
            S_INIT_WR: w_next_state = S_IDLE;
            S_IDLE: begin
                if (irq && en) begin
                    w_next_state = S_RD_ADDR;
                end else if (w_pending) begin
                    w_next_state = S_RESYNC;
                end
            end
            S_RD_ADDR: w_next_state = S_RD_CAP;
            S_RD_CAP:  w_next_state = readdata[0] ? S_ACK : S_IDLE;
            S_ACK:     w_next_state = S_IDLE;
            S_RESYNC:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Output logic: bus signals are decoded from the upcoming state so they register in step
    always_comb begin
        w_address    = ADDR_STATUS;
        w_chipselect = 1'b0;
        w_write_n    = 1'b1;
        w_writedata  = 16'h0000;
        case (w_next_state)
            S_INIT_WR: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = ADDR_CTRL;
                w_writedata  = CTRL_INIT;
            end
            S_RD_ADDR: begin
                w_chipselect = 1'b1;
            end
            S_ACK: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
            end
            S_RESYNC: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = ADDR_PERIOD_LO;
            end
            default: ;
        endcase

        w_ready      = r_ready | (w_next_state == S_IDLE);
        w_tick_pulse = (r_state == S_ACK);
        w_tick_count = r_tick_count;
        if (r_state == S_ACK) begin
            w_tick_count = r_tick_count + TICK_W'(1);
        end

        w_spurious_count = r_spurious_count;
        if ((r_state == S_RD_CAP) && !readdata[0] && (r_spurious_count != SPUR_MAX)) begin
            w_spurious_count = r_spurious_count + 8'd1;
        end

        // A request landing during the reload write stays pending for another reload
        w_pending_next = (r_state == S_RESYNC) ? resync : w_pending;
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address        <= ADDR_STATUS;
            r_chipselect     <= 1'b0;
            r_write_n        <= 1'b1;
            r_writedata      <= 16'h0000;
            r_ready          <= 1'b0;
            r_tick_pulse     <= 1'b0;
            r_tick_count     <= '0;
            r_spurious_count <= 8'd0;
            r_pending        <= 1'b0;
        end else begin
            r_address        <= w_address;
            r_chipselect     <= w_chipselect;
            r_write_n        <= w_write_n;
            r_writedata      <= w_writedata;
            r_ready          <= w_ready;
            r_tick_pulse     <= w_tick_pulse;
            r_tick_count     <= w_tick_count;
            r_spurious_count <= w_spurious_count;
            r_pending        <= w_pending_next;
        end
    end

    assign address        = r_address;
    assign chipselect     = r_chipselect;
    assign write_n        = r_write_n;
    assign writedata      = r_writedata;
    assign ready          = r_ready;
    assign tick_pulse     = r_tick_pulse;
    assign tick_count     = r_tick_count;
    assign spurious_count = r_spurious_count;

endmodule

// File: tb/tb_com_timer_tick_master.sv
// Bench for com_timer_tick_master: a small interval-timer model on the bus,
// directed timing checks and randomized service operations against counters kept here.
`timescale 1ns/1ps
module tb_com_timer_tick_master;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        en     = 1'b1;
    logic        resync = 1'b0;
    logic        irq;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        ready;
    logic        tick_pulse;
    logic [31:0] tick_count;
    logic [7:0]  spurious_count;

    logic [2:0]  address4;
    logic        chipselect4;
    logic        write_n4;
    logic [15:0] writedata4;
    logic        ready4;
    logic        tick_pulse4;
    logic [3:0]  tick_count4;
    logic [7:0]  spurious_count4;

    com_timer_tick_master u_dut (
        .clk(clk), .reset(reset), .en(en), .resync(resync), .irq(irq),
        .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .ready(ready),
        .tick_pulse(tick_pulse), .tick_count(tick_count),
        .spurious_count(spurious_count)
    );

    // Narrow-counter instance fed the same inputs; only its tick counter is examined
    com_timer_tick_master #(.TICK_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .resync(resync), .irq(irq),
        .address(address4), .chipselect(chipselect4), .write_n(write_n4),
        .writedata(writedata4), .readdata(readdata), .ready(ready4),
        .tick_pulse(tick_pulse4), .tick_count(tick_count4),
        .spurious_count(spurious_count4)
    );

    always #5 clk = ~clk;

    // Timer register model
    logic        t_timeout;
    logic [15:0] t_ctrl;
    logic        fire      = 1'b0;
    logic        force_irq = 1'b0;
    logic        force_st  = 1'b0;
    logic [15:0] force_val = 16'h0000;
    logic        run_bit   = 1'b1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_timeout <= 1'b0;
            t_ctrl    <= 16'h0000;
            readdata  <= 16'h0000;
        end else begin
            readdata <= 16'h0000;
            if (chipselect && write_n) begin
                if (force_st)
                    readdata <= force_val;
                else if (address == 3'd0)
                    readdata <= {14'b0, run_bit, t_timeout};
                else if (address == 3'd1)
                    readdata <= t_ctrl;
            end
            if (fire) t_timeout <= 1'b1;
            if (chipselect && !write_n) begin
                if (address == 3'd0) t_timeout <= 1'b0;
                if (address == 3'd1) t_ctrl <= writedata;
            end
        end
    end

    assign irq = force_irq | (t_timeout & t_ctrl[0]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rd    = 0;
    int          last_rd_cyc = -1;
    logic [2:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    int          wq_cyc[$];

    int m_ticks = 0;
    int m_spur  = 0;
    int m_per   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample on the falling edge, log bus cycles, check idle values
    task automatic step();
        @(negedge clk);
        if (chipselect) begin
            if (write_n) begin
                n_rd++;
                last_rd_cyc = cyc;
            end else begin
                wq_addr.push_back(address);
                wq_data.push_back(writedata);
                wq_cyc.push_back(cyc);
            end
        end else begin
            chk("bus_idle", {28'b0, write_n, address}, {28'b0, 1'b1, 3'd0});
            chk("bus_idle_wd", 32'(writedata), 32'h0);
        end
    endtask

    function automatic int n_wr(input logic [2:0] a);
        int c = 0;
        foreach (wq_addr[i]) if (wq_addr[i] == a) c++;
        return c;
    endfunction

    task automatic chk_last_wr(input string tag, input logic [2:0] a, input logic [15:0] d, input int c);
        chk({tag, "_nonempty"}, 32'(wq_addr.size() > 0), 32'd1);
        if (wq_addr.size() > 0) begin
            chk({tag, "_addr"}, 32'(wq_addr[$]), 32'(a));
            chk({tag, "_data"}, 32'(wq_data[$]), 32'(d));
            chk({tag, "_cyc"},  32'(wq_cyc[$]),  32'(c));
        end
    endtask

    task automatic service();
        fire = 1'b1;
        step();
        fire = 1'b0;
        repeat (6) step();
        m_ticks++;
    endtask

    task automatic spurious_one(input logic [15:0] st);
        force_val = st;
        force_st  = 1'b1;
        force_irq = 1'b1;
        step();
        force_irq = 1'b0;
        repeat (3) step();
        force_st = 1'b0;
        if (m_spur < 255) m_spur++;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ticks"}, tick_count, 32'(m_ticks));
        chk({tag, "_ticks4"}, 32'(tick_count4), 32'(m_ticks % 16));
        chk({tag, "_spur"}, 32'(spurious_count), 32'(m_spur));
        chk({tag, "_period_wr"}, 32'(n_wr(3'd2)), 32'(m_per));
    endtask

    initial begin
        int n;
        int r;
        int rd0;
        int w0;
        int op;
        int gap;

        // Reset state
        repeat (2) step();
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_cs", 32'(chipselect), 32'd0);
        chk("rst_wn", 32'(write_n), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_pulse", 32'(tick_pulse), 32'd0);
        chk("rst_ticks", tick_count, 32'd0);
        chk("rst_spur", 32'(spurious_count), 32'd0);

        // Init write on the first clock, ready from the second
        reset = 1'b0;
        r = cyc;
        step();
        chk_last_wr("init_wr", 3'd1, 16'h0001, r + 1);
        chk("init_ready_early", 32'(ready), 32'd0);
        step();
        chk("init_ready", 32'(ready), 32'd1);
        repeat (4) step();
        chk("init_one_wr", 32'(wq_addr.size()), 32'd1);
        chk("init_no_rd", 32'(n_rd), 32'd0);

        // irq service timing with status 16'h0003
        run_bit = 1'b1;
        fire = 1'b1;
        step();
        fire = 1'b0;
        n = cyc;
        chk("svc_irq_hi", 32'(irq), 32'd1);
        step();
        chk("svc_rd_cyc", 32'(last_rd_cyc), 32'(n + 1));
        step();
        step();
        chk_last_wr("svc_ack", 3'd0, 16'h0000, n + 3);
        chk("svc_pulse_early", 32'(tick_pulse), 32'd0);
        step();
        chk("svc_pulse", 32'(tick_pulse), 32'd1);
        chk("svc_ticks", tick_count, 32'd1);
        chk("svc_irq_lo", 32'(irq), 32'd0);
        step();
        chk("svc_pulse_off", 32'(tick_pulse), 32'd0);
        m_ticks = 1;
        repeat (2) step();

        // Narrow counter wraps 15 -> 0 and ends at 1 after 17 timeouts
        repeat (15) service();
        chk("wrap_ticks4_zero", 32'(tick_count4), 32'd0);
        chk("wrap_ticks16", tick_count, 32'd16);
        service();
        chk("wrap_ticks4_one", 32'(tick_count4), 32'd1);

        // Spurious interrupt: no acknowledge write
        w0 = wq_addr.size();
        spurious_one(16'h0002);
        chk("spur_one", 32'(spurious_count), 32'd1);
        chk("spur_no_wr", 32'(wq_addr.size()), 32'(w0));

        // Two resync pulses during a service merge into one reload after the ack
        w0 = n_wr(3'd2);
        fire = 1'b1;
        step();
        fire = 1'b0;
        n = cyc;
        step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        step();
        chk_last_wr("merge_reload", 3'd2, 16'h0000, n + 5);
        repeat (4) step();
        chk("merge_one", 32'(n_wr(3'd2)), 32'(w0 + 1));
        m_ticks++;
        m_per++;

        // irq and resync together in IDLE: service first, then reload
        fire = 1'b1;
        step();
        fire = 1'b0;
        n = cyc;
        resync = 1'b1;
        step();
        resync = 1'b0;
        step();
        step();
        chk_last_wr("prio_ack", 3'd0, 16'h0000, n + 3);
        step();
        step();
        chk_last_wr("prio_reload", 3'd2, 16'h0000, n + 5);
        m_ticks++;
        m_per++;
        repeat (3) step();
        chk_model("prio");

        // en low blocks new service while irq is high
        en = 1'b0;
        rd0 = n_rd;
        fire = 1'b1;
        step();
        fire = 1'b0;
        repeat (10) step();
        chk("en_no_rd", 32'(n_rd), 32'(rd0));
        chk("en_irq_held", 32'(irq), 32'd1);
        chk("en_ticks_hold", tick_count, 32'(m_ticks));
        en = 1'b1;
        repeat (6) step();
        m_ticks++;
        chk_model("en");

        // Randomized operations
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    run_bit = 1'($urandom_range(0, 1));
                    service();
                end
                1: spurious_one(16'($urandom) & 16'hFFFE);
                2: begin
                    resync = 1'b1;
                    n = cyc;
                    step();
                    resync = 1'b0;
                    chk_last_wr("rnd_reload", 3'd2, 16'h0000, n + 1);
                    m_per++;
                end
                default: begin
                    en = 1'b0;
                    rd0 = n_rd;
                    fire = 1'b1;
                    step();
                    fire = 1'b0;
                    gap = int'($urandom_range(1, 8));
                    repeat (gap) step();
                    chk("rnd_en_no_rd", 32'(n_rd), 32'(rd0));
                    en = 1'b1;
                    repeat (6) step();
                    m_ticks++;
                end
            endcase
            repeat (2) step();
            chk_model("rnd");
        end

        // Spurious counter saturates at 255
        w0 = wq_addr.size();
        force_val = 16'h0002;
        force_st  = 1'b1;
        force_irq = 1'b1;
        repeat (905) step();
        force_irq = 1'b0;
        repeat (4) step();
        force_st = 1'b0;
        m_spur = 255;
        chk("sat_spur", 32'(spurious_count), 32'd255);
        chk("sat_no_wr", 32'(wq_addr.size()), 32'(w0));
        chk_model("sat");

        // Reset during RD_CAP returns outputs immediately, INIT reruns
        fire = 1'b1;
        step();
        fire = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(chipselect), 32'd0);
        chk("mid_rst_wn", 32'(write_n), 32'd1);
        chk("mid_rst_addr", 32'(address), 32'd0);
        chk("mid_rst_wd", 32'(writedata), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_ticks", tick_count, 32'd0);
        chk("mid_rst_spur", 32'(spurious_count), 32'd0);
        chk("mid_rst_pulse", 32'(tick_pulse), 32'd0);
        repeat (2) step();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        rd0 = n_rd;
        reset = 1'b0;
        r = cyc;
        step();
        chk_last_wr("reinit_wr", 3'd1, 16'h0001, r + 1);
        step();
        chk("reinit_ready", 32'(ready), 32'd1);
        repeat (6) step();
        chk("reinit_one_wr", 32'(wq_addr.size()), 32'd1);
        chk("reinit_no_rd", 32'(n_rd), 32'(rd0));
        chk("reinit_ticks", tick_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
